butterfly_pipe: RTL and testbench
=================================

BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 The module SHALL have these parameters:
  - WIDTH, 16, data width of each real/imag component (signed, Q1.(WIDTH-1)).
  - TW_WIDTH, 16, twiddle component width (signed, Q1.(TW_WIDTH-1)).
  - ROUND, 1, 0 = truncate, 1 = round-half-up at every right shift.
  - SCALE, 0, 1 = divide both outputs by 2 (block-floating stage scaling).
REQ-002 The module SHALL have these ports:
  - clk  in  1  clock.
  - rst  in  1  reset, synchronous, active-high.
  - in_valid  in  1  input beat valid.
  - in_ready  out  1  module accepts the beat this cycle.
  - a_real, a_imag  in  WIDTH  operand A.
  - b_real, b_imag  in  WIDTH  operand B.
  - tw_real, tw_imag  in  TW_WIDTH  twiddle W.
  - out_valid  out  1  output beat valid.
  - out_ready  in  1  downstream accepts.
  - out1_real, out1_imag  out  WIDTH  A + B*W.
  - out2_real, out2_imag  out  WIDTH  A - B*W.
  - ovf  out  1  sticky saturation flag.
  - ovf_clr  in  1  clears ovf.
REQ-003 The design SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 A beat SHALL transfer in on in_valid && in_ready and out on out_valid && out_ready.
REQ-005 Pipeline SHALL be three register stages, so latency from input transfer to out_valid is exactly 3 cycles when not stalled.
  - S1: register operands and the four products.
  - S2: complex combine, round/shift to B*W.
  - S3: add/sub, optional scale, saturate.
REQ-006 stall = out_valid && !out_ready; while stall, all stages SHALL hold, in_ready SHALL be 0, and outputs SHALL remain stable.
REQ-007 in_ready SHALL equal !stall (combinational); bubbles SHALL be absorbed, so stage valids advance independently of data.
REQ-008 Full throughput SHALL be one beat per cycle with no loss, duplication or reordering under any out_ready pattern.
REQ-009 Products SHALL be full precision (WIDTH+TW_WIDTH bits); combine SHALL use WIDTH+TW_WIDTH+1 bits: re = br*tr - bi*ti, im = br*ti + bi*tr.
REQ-010 B*W SHALL be arithmetic-shifted right by TW_WIDTH-1, adding 2^(TW_WIDTH-2) first when ROUND=1, and kept at WIDTH+1 bits (no clipping).
REQ-011 Sums/differences SHALL be formed at WIDTH+2 bits. When SCALE=1 they SHALL be shifted right 1 with the same ROUND rule. Each SHALL then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-012 ovf SHALL set in the cycle after any of the four outputs saturates on a transferring beat.
REQ-013 ovf SHALL clear on ovf_clr; simultaneous set and clear SHALL leave ovf = 1.
REQ-014 Output data while out_valid = 0 is don't-care but SHALL be deterministic (registers hold).

Reset
REQ-015 On rst, all stage valids, out_valid and ovf SHALL be 0 on the next edge; in_ready SHALL be 1 one cycle after rst deasserts.
REQ-016 rst mid-operation SHALL discard all in-flight beats; no out_valid SHALL appear for them.
REQ-017 Data registers SHALL reset to 0.

Structure
REQ-018 Default widths, Q-format helper constants and the saturate/round width rules SHALL live in shared package fft_pkg for reuse by the FFT stage controller.
REQ-019 Saturation-with-rounding SHALL be one sub-module, sat_round (parametrised in/out width, shift, ROUND), instantiated four times in S3 and reused in S2 for the shift.
REQ-020 No vendor DSP primitives SHALL be instantiated; multiplies SHALL be inferred.

Verification (WIDTH=TW_WIDTH=16 unless noted)
REQ-021 ROUND=1, SCALE=0: a=(0x1000,0), b=(0x2000,0), tw=(0x7FFF,0) -> 3 cycles later out1=(0x3000,0), out2=(0xF000,0), ovf=0; with ROUND=0, out1_real=0x2FFF.
REQ-022 a=(0x0100,0x0200), b=(0x1000,0), tw=(0,0x8000) -> out1=(0x0100,0xF200), out2=(0x0100,0x1200).
REQ-023 a=(0x7000,0), b=(0x4000,0), tw=(0x7FFF,0) -> out1_real=0x7FFF, out2_real=0x3000, ovf=1 next cycle. ovf_clr pulsed together with another saturating beat -> ovf stays 1.
REQ-024 SCALE=1, ROUND=1: same stimulus as REQ-023 -> out1_real=0x5800, out2_real=0x1800, ovf=0.
REQ-025 Stream 32 random beats with out_ready random 50%, including a 4-cycle low run -> output matches a reference model bit-exactly and in order; in_ready=0 exactly while stall.
REQ-026 Assert rst with 3 beats in flight -> out_valid=0 next cycle; none of the 3 beats emerges afterwards.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath sizing: default component widths, Q-format constants and
// the intermediate width rules used by the butterfly and the stage controller.
package fft_pkg;

    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_TW_WIDTH = 16;

    // Full-precision product of a data and a twiddle component.
    function automatic int unsigned prod_w(input int unsigned w, input int unsigned tw);
        return w + tw;
    endfunction

    // Complex combine (sum/difference of two products) needs one growth bit.
    function automatic int unsigned comb_w(input int unsigned w, input int unsigned tw);
        return w + tw + 1;
    endfunction

    // B*W after the Q1.(TW-1) renormalising shift, kept unclipped.
    function automatic int unsigned bw_w(input int unsigned w);
        return w + 1;
    endfunction

    // A +/- B*W before optional scaling and final saturation.
    function automatic int unsigned sum_w(input int unsigned w);
        return w + 2;
    endfunction

    // Right shift that renormalises a product back to Q1.(W-1).
    function automatic int unsigned tw_shift(input int unsigned tw);
        return tw - 1;
    endfunction

endpackage

// File: rtl/butterfly_pipe_sat_round.sv
// Arithmetic right shift with optional round-half-up, followed by saturation
// of the result to a signed OUT_W-bit range.
module sat_round
    import fft_pkg::*;
#(
    parameter int unsigned IN_W  = sum_w(DEF_WIDTH),
    parameter int unsigned OUT_W = DEF_WIDTH,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned ROUND = 1
) (
    input  logic signed [IN_W-1:0]  i_data,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_sat
);

    localparam int unsigned EXT_W = IN_W + 1;

    // One guard bit absorbs the rounding bias without wrapping.
    localparam logic signed [EXT_W-1:0] BIAS =
        (ROUND != 0 && SHIFT > 0) ? ({{(EXT_W-1){1'b0}}, 1'b1} << (SHIFT > 0 ? SHIFT - 1 : 0))
                                  : '0;
    localparam logic signed [EXT_W-1:0] MAXV = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MINV = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_sh;

    assign w_ext = EXT_W'(i_data) + BIAS;
    assign w_sh  = w_ext >>> SHIFT;

    always_comb begin
        o_sat  = 1'b0;
        o_data = w_sh[OUT_W-1:0];
        if (w_sh > MAXV) begin
            o_sat  = 1'b1;
            o_data = MAXV[OUT_W-1:0];
        end else if (w_sh < MINV) begin
            o_sat  = 1'b1;
            o_data = MINV[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly: out1 = A + B*W, out2 = A - B*W, three-stage pipeline
// with a global stall, optional stage scaling and a sticky saturation flag.
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned TW_WIDTH = DEF_TW_WIDTH,
    parameter int unsigned ROUND    = 1,
    parameter int unsigned SCALE    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WIDTH-1:0]    a_real,
    input  logic signed [WIDTH-1:0]    a_imag,
    input  logic signed [WIDTH-1:0]    b_real,
    input  logic signed [WIDTH-1:0]    b_imag,
    input  logic signed [TW_WIDTH-1:0] tw_real,
    input  logic signed [TW_WIDTH-1:0] tw_imag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [WIDTH-1:0]    out1_real,
    output logic signed [WIDTH-1:0]    out1_imag,
    output logic signed [WIDTH-1:0]    out2_real,
    output logic signed [WIDTH-1:0]    out2_imag,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam int unsigned PROD_W = prod_w(WIDTH, TW_WIDTH);
    localparam int unsigned COMB_W = comb_w(WIDTH, TW_WIDTH);
    localparam int unsigned BW_W   = bw_w(WIDTH);
    localparam int unsigned SUM_W  = sum_w(WIDTH);

    logic w_stall;
    logic r_v1, r_v2, r_v3;

    // Whole pipe freezes only when the output register is full and blocked.
    assign w_stall   = r_v3 && !out_ready;
    assign in_ready  = !w_stall;
    assign out_valid = r_v3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (!w_stall) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    // S1: operands and full-precision partial products.
    logic signed [PROD_W-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [PROD_W-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic signed [WIDTH-1:0]  r_a1_re, r_a1_im;

    assign w_p_rr = PROD_W'(b_real) * PROD_W'(tw_real);
    assign w_p_ii = PROD_W'(b_imag) * PROD_W'(tw_imag);
    assign w_p_ri = PROD_W'(b_real) * PROD_W'(tw_imag);
    assign w_p_ir = PROD_W'(b_imag) * PROD_W'(tw_real);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a1_re <= '0;
            r_a1_im <= '0;
            r_p_rr  <= '0;
            r_p_ii  <= '0;
            r_p_ri  <= '0;
            r_p_ir  <= '0;
        end else if (in_valid && !w_stall) begin
            r_a1_re <= a_real;
            r_a1_im <= a_imag;
            r_p_rr  <= w_p_rr;
            r_p_ii  <= w_p_ii;
            r_p_ri  <= w_p_ri;
            r_p_ir  <= w_p_ir;
        end
    end

    // S2: complex combine and renormalise B*W.
    logic signed [COMB_W-1:0] w_comb_re, w_comb_im;
    logic signed [BW_W-1:0]   w_bw_re, w_bw_im;
    logic signed [BW_W-1:0]   r_bw_re, r_bw_im;
    logic signed [WIDTH-1:0]  r_a2_re, r_a2_im;
    logic                     w_s2_sat_re, w_s2_sat_im;
    logic                     w_unused_s2;

    assign w_comb_re = COMB_W'(r_p_rr) - COMB_W'(r_p_ii);
    assign w_comb_im = COMB_W'(r_p_ri) + COMB_W'(r_p_ir);

    sat_round #(
        .IN_W (COMB_W),
        .OUT_W(BW_W),
        .SHIFT(tw_shift(TW_WIDTH)),
        .ROUND(ROUND)
    ) u_s2_re (
        .i_data(w_comb_re),
        .o_data(w_bw_re),
        .o_sat (w_s2_sat_re)
    );

    sat_round #(
        .IN_W (COMB_W),
        .OUT_W(BW_W),
        .SHIFT(tw_shift(TW_WIDTH)),
        .ROUND(ROUND)
    ) u_s2_im (
        .i_data(w_comb_im),
        .o_data(w_bw_im),
        .o_sat (w_s2_sat_im)
    );

    // B*W only reaches the clip point for (-1)*(-1); that case is left to S3.
    assign w_unused_s2 = w_s2_sat_re | w_s2_sat_im;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a2_re <= '0;
            r_a2_im <= '0;
            r_bw_re <= '0;
            r_bw_im <= '0;
        end else if (r_v1 && !w_stall) begin
            r_a2_re <= r_a1_re;
            r_a2_im <= r_a1_im;
            r_bw_re <= w_bw_re;
            r_bw_im <= w_bw_im;
        end
    end

    // S3: add/sub, optional halving, saturate.
    logic signed [SUM_W-1:0] w_s1_re, w_s1_im, w_s2_re, w_s2_im;
    logic signed [WIDTH-1:0] w_o1_re, w_o1_im, w_o2_re, w_o2_im;
    logic [3:0]              w_sat3;
    logic signed [WIDTH-1:0] r_o1_re, r_o1_im, r_o2_re, r_o2_im;
    logic                    r_sat3;
    logic                    r_ovf;

    assign w_s1_re = SUM_W'(r_a2_re) + SUM_W'(r_bw_re);
    assign w_s1_im = SUM_W'(r_a2_im) + SUM_W'(r_bw_im);
    assign w_s2_re = SUM_W'(r_a2_re) - SUM_W'(r_bw_re);
    assign w_s2_im = SUM_W'(r_a2_im) - SUM_W'(r_bw_im);

    sat_round #(.IN_W(SUM_W), .OUT_W(WIDTH), .SHIFT(SCALE), .ROUND(ROUND)) u_o1_re (
        .i_data(w_s1_re), .o_data(w_o1_re), .o_sat(w_sat3[0])
    );
    sat_round #(.IN_W(SUM_W), .OUT_W(WIDTH), .SHIFT(SCALE), .ROUND(ROUND)) u_o1_im (
        .i_data(w_s1_im), .o_data(w_o1_im), .o_sat(w_sat3[1])
    );
    sat_round #(.IN_W(SUM_W), .OUT_W(WIDTH), .SHIFT(SCALE), .ROUND(ROUND)) u_o2_re (
        .i_data(w_s2_re), .o_data(w_o2_re), .o_sat(w_sat3[2])
    );
    sat_round #(.IN_W(SUM_W), .OUT_W(WIDTH), .SHIFT(SCALE), .ROUND(ROUND)) u_o2_im (
        .i_data(w_s2_im), .o_data(w_o2_im), .o_sat(w_sat3[3])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_o1_re <= '0;
            r_o1_im <= '0;
            r_o2_re <= '0;
            r_o2_im <= '0;
            r_sat3  <= 1'b0;
        end else if (r_v2 && !w_stall) begin
            r_o1_re <= w_o1_re;
            r_o1_im <= w_o1_im;
            r_o2_re <= w_o2_re;
            r_o2_im <= w_o2_im;
            r_sat3  <= |w_sat3;
        end
    end

    // Saturation is recorded only when the beat actually leaves; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= (r_v3 && out_ready && r_sat3) || (r_ovf && !ovf_clr);
        end
    end

    assign out1_real = r_o1_re;
    assign out1_imag = r_o1_im;
    assign out2_real = r_o2_re;
    assign out2_imag = r_o2_im;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: three configurations (round, truncate,
// round+scale) share stimulus; a negedge monitor pops and compares.
module tb_butterfly_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, ovf_clr;
    logic [15:0] ar, ai, br, bi, tr, ti;
    logic        ir [3];
    logic        ov [3];
    logic        ovf [3];
    logic [15:0] o1r [3], o1i [3], o2r [3], o2i [3];

    typedef struct packed { logic [15:0] ar, ai, br, bi, tr, ti; } beat_t;
    // v[cfg] = {out1_real, out1_imag, out2_real, out2_imag}; cfg0 R1S0, cfg1 R0S0, cfg2 R1S1
    typedef struct packed { logic [2:0][3:0][15:0] v; logic [2:0] sat; } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    int   or_mode  = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        butterfly_pipe #(
            .WIDTH(16), .TW_WIDTH(16), .ROUND(k == 1 ? 0 : 1), .SCALE(k == 2 ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[k]),
            .a_real(ar), .a_imag(ai), .b_real(br), .b_imag(bi),
            .tw_real(tr), .tw_imag(ti),
            .out_valid(ov[k]), .out_ready(out_ready),
            .out1_real(o1r[k]), .out1_imag(o1i[k]), .out2_real(o2r[k]), .out2_imag(o2i[k]),
            .ovf(ovf[k]), .ovf_clr(ovf_clr)
        );
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic longint fl(input longint x, input longint d);
        longint q;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint clip(input longint x, input int w, output bit s);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        s  = (x > hi) || (x < lo);
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    function automatic exp_t model(input beat_t b);
        exp_t   e;
        longint bwr, bwi, x;
        longint s [4];
        bit     st, rnd, scl;
        e = '0;
        for (int k = 0; k < 3; k++) begin
            rnd = (k != 1);
            scl = (k == 2);
            bwr = longint'($signed(b.br)) * longint'($signed(b.tr)) - longint'($signed(b.bi)) * longint'($signed(b.ti));
            bwi = longint'($signed(b.br)) * longint'($signed(b.ti)) + longint'($signed(b.bi)) * longint'($signed(b.tr));
            bwr = clip(fl(bwr + (rnd ? 16384 : 0), 32768), 17, st);
            bwi = clip(fl(bwi + (rnd ? 16384 : 0), 32768), 17, st);
            s[0] = longint'($signed(b.ar)) + bwr;
            s[1] = longint'($signed(b.ai)) + bwi;
            s[2] = longint'($signed(b.ar)) - bwr;
            s[3] = longint'($signed(b.ai)) - bwi;
            for (int j = 0; j < 4; j++) begin
                x = s[j];
                if (scl) x = fl(x + (rnd ? 1 : 0), 2);
                x = clip(x, 16, st);
                e.sat[k] = e.sat[k] | st;
                e.v[k][3-j] = 16'(x);
            end
        end
        return e;
    endfunction

    function automatic exp_t mkexp(input logic [63:0] c0, c1, c2, input logic [2:0] sat);
        exp_t e;
        e.v[0] = c0;
        e.v[1] = c1;
        e.v[2] = c2;
        e.sat  = sat;
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input beat_t b, input exp_t e);
        int unsigned n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        {ar, ai, br, bi, tr, ti} = b;
        in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready_any();
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc) sb.push_back(e);
        else chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    function automatic bit in_ready_any();
        return ir[0];
    endfunction

    task automatic wait_valid(output int n);
        n = 0;
        while (!ov[0] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // out_ready driver: 0 = always 1, 1 = always 0, 2 = random with a 4-cycle low run
    int rnd_cyc = 0;
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: begin
                rnd_cyc++;
                if (rnd_cyc >= 6 && rnd_cyc <= 9) out_ready = 1'b0;
                else out_ready = 1'($urandom_range(0, 1));
            end
        endcase
    end

    // Monitor
    bit          exp_ovf [3];
    bit          prev_stall [3];
    logic [63:0] prev_out [3];
    always @(negedge clk) begin
        exp_t e;
        bit   xfer;
        if (mon_en) begin
            e    = '0;
            xfer = 1'b0;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("cfg%0d_ovf", k), 32'(ovf[k]), 32'(exp_ovf[k]));
                chk($sformatf("cfg%0d_in_ready", k), 32'(ir[k]), 32'(!(ov[k] && !out_ready)));
                if (prev_stall[k]) begin
                    chk($sformatf("cfg%0d_stall_valid", k), 32'(ov[k]), 32'd1);
                    chk($sformatf("cfg%0d_stall_hold", k), {o1r[k], o1i[k]}, prev_out[k][63:32]);
                    chk($sformatf("cfg%0d_stall_hold2", k), {o2r[k], o2i[k]}, prev_out[k][31:0]);
                end
            end
            if (sb.size() == 0) begin
                for (int k = 0; k < 3; k++) chk($sformatf("cfg%0d_unexpected_out", k), 32'(ov[k]), 32'd0);
            end else if (ov[0] && out_ready && !rst) begin
                xfer = 1'b1;
                e = sb.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("cfg%0d_out_valid", k), 32'(ov[k]), 32'd1);
                    chk($sformatf("cfg%0d_out1_real", k), 32'(o1r[k]), 32'(e.v[k][3]));
                    chk($sformatf("cfg%0d_out1_imag", k), 32'(o1i[k]), 32'(e.v[k][2]));
                    chk($sformatf("cfg%0d_out2_real", k), 32'(o2r[k]), 32'(e.v[k][1]));
                    chk($sformatf("cfg%0d_out2_imag", k), 32'(o2i[k]), 32'(e.v[k][0]));
                end
            end
            if (rst) sb.delete();
            for (int k = 0; k < 3; k++) begin
                exp_ovf[k]    = rst ? 1'b0 : ((xfer && e.sat[k]) || (exp_ovf[k] && !ovf_clr));
                prev_stall[k] = !rst && ov[k] && !out_ready;
                prev_out[k]   = {o1r[k], o1i[k], o2r[k], o2i[k]};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    n;
        beat_t b;
        exp_t  eA, eB, eC, eD, eE;
        eA = mkexp(64'h3000_0000_F000_0000, 64'h2FFF_0000_F001_0000, 64'h1800_0000_F800_0000, 3'b000);
        eB = mkexp(64'h0100_F200_0100_1200, 64'h0100_F200_0100_1200, 64'h0080_F900_0080_0900, 3'b000);
        eC = mkexp(64'h7FFF_0000_3000_0000, 64'h7FFF_0000_3001_0000, 64'h5800_0000_1800_0000, 3'b011);
        eD = mkexp(64'hC000_4000_8000_C000, 64'hBFFF_3FFF_8000_C001, 64'hE000_2000_A000_E000, 3'b011);
        eE = mkexp(64'h0800_1800_F800_E800, 64'h0800_1800_F800_E800, 64'h0400_0C00_FC00_F400, 3'b000);

        rst = 1'b1; in_valid = 1'b0; ovf_clr = 1'b0;
        {ar, ai, br, bi, tr, ti} = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cfg%0d_rst_valid", k), 32'(ov[k]), 32'd0);
            chk($sformatf("cfg%0d_rst_ovf", k), 32'(ovf[k]), 32'd0);
            chk($sformatf("cfg%0d_rst_data", k), {o1r[k], o2i[k]}, 32'd0);
        end
        idle(1);
        chk("rst_in_ready", 32'(ir[0]), 32'd1);
        mon_en = 1'b1;
        idle(1);

        // latency with the basic vector
        send(beat_t'{16'h1000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000}, eA);
        wait_valid(n);
        chk("latency", 32'(n + 1), 32'd3);
        idle(3);

        send(beat_t'{16'h0100, 16'h0200, 16'h1000, 16'h0000, 16'h0000, 16'h8000}, eB);
        send(beat_t'{16'h0000, 16'h0000, 16'h2000, 16'h1000, 16'h4000, 16'h4000}, eE);
        idle(5);
        chk("ovf_clean", 32'(ovf[0]), 32'd0);

        // saturation sets ovf; clear coinciding with a saturating beat keeps it
        send(beat_t'{16'h7000, 16'h0000, 16'h4000, 16'h0000, 16'h7FFF, 16'h0000}, eC);
        idle(5);
        chk("ovf_set", 32'(ovf[0]), 32'd1);
        chk("ovf_scaled_clean", 32'(ovf[2]), 32'd0);
        send(beat_t'{16'h7000, 16'h0000, 16'h4000, 16'h0000, 16'h7FFF, 16'h0000}, eC);
        wait_valid(n);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_set_and_clr", 32'(ovf[0]), 32'd1);
        idle(2);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf[0]), 32'd0);

        send(beat_t'{16'h8000, 16'h0000, 16'h4000, 16'h4000, 16'h7FFF, 16'h0000}, eD);
        idle(6);

        // random stream under random backpressure
        or_mode = 2;
        for (int i = 0; i < 32; i++) begin
            b = beat_t'{16'($urandom), 16'($urandom), 16'($urandom),
                        16'($urandom), 16'($urandom), 16'($urandom)};
            send(b, model(b));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            idle(1);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);

        // reset with three beats in flight
        or_mode = 1;
        idle(3);
        for (int i = 0; i < 3; i++) begin
            b = beat_t'{16'(i * 16'h0100), 16'h0000, 16'h1000, 16'h0000, 16'h7FFF, 16'h0000};
            send(b, model(b));
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) chk($sformatf("cfg%0d_rst_flush", k), 32'(ov[k]), 32'd0);
        or_mode = 0;
        idle(1);
        chk("rst_flush_in_ready", 32'(ir[0]), 32'd1);
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
